// File: rtl/register_dump_tx.sv
// register_dump_tx: walks the register file and streams every register to a UART
// transmitter, most-significant byte first, one byte per tx_start/tx_done handshake.
module register_dump_tx #(
    parameter int NB      = 32,
    parameter int REGS    = 5,
    parameter int TAM_REG = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    output logic [REGS-1:0]    o_mips_register_number,
    input  logic [NB-1:0]      i_mips_register_data,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_start,
    input  logic               i_tx_done,
    output logic               o_busy,
    output logic               o_done
);
    localparam int NBY = NB / NB_BYTE;
    localparam int CW  = (NBY > 1) ? $clog2(NBY) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, NEXT, DONE} state_t;

    state_t                      state_q;
    logic [REGS-1:0]             idx_q;
    logic [CW-1:0]               cnt_q;
    logic [NB-1:0]               hold_q;
    logic [NBY-1:0][NB_BYTE-1:0] bytes;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (i_start) begin
                    idx_q   <= '0;
                    state_q <= LOAD;
                end
                LOAD: begin
                    hold_q  <= i_mips_register_data;
                    cnt_q   <= '0;
                    state_q <= SEND;
                end
                SEND: state_q <= WAIT;
                WAIT: if (i_tx_done) begin
                    if (cnt_q == CW'(NBY - 1)) state_q <= NEXT;
                    else begin
                        cnt_q   <= cnt_q + CW'(1);
                        state_q <= SEND;
                    end
                end
                NEXT: if (idx_q == REGS'(TAM_REG - 1)) state_q <= DONE;
                else begin
                    idx_q   <= idx_q + REGS'(1);
                    state_q <= LOAD;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Byte 0 of the packed view is the least-significant byte, so count 0 picks the top one.
    assign bytes                  = hold_q;
    assign o_tx_data              = bytes[CW'(NBY - 1) - cnt_q];
    assign o_mips_register_number = idx_q;
    assign o_tx_start             = (state_q == SEND);
    assign o_busy                 = (state_q != IDLE);
    assign o_done                 = (state_q == DONE);
endmodule

// File: tb/tb_register_dump_tx.sv
// tb_register_dump_tx: scoreboard bench with register-file and UART transmitter models.
module tb_register_dump_tx;
    logic        i_clk = 0;
    logic        i_reset;
    logic        i_start;
    logic [4:0]  o_mips_register_number;
    logic [31:0] i_mips_register_data;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic        i_tx_done;
    logic        o_busy;
    logic        o_done;
    logic        override;
    logic [7:0]  exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    register_dump_tx dut (
        .i_clk                 (i_clk),
        .i_reset               (i_reset),
        .i_start               (i_start),
        .o_mips_register_number(o_mips_register_number),
        .i_mips_register_data  (i_mips_register_data),
        .o_tx_data             (o_tx_data),
        .o_tx_start            (o_tx_start),
        .i_tx_done             (i_tx_done),
        .o_busy                (o_busy),
        .o_done                (o_done)
    );

    always #5 i_clk = ~i_clk;

    assign i_mips_register_data = override ? 32'hFFFF_FFFF : 32'h1234_5600 + 32'(o_mips_register_number);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_start"}, 32'(o_tx_start), 0);
        check({tag, "_busy"}, 32'(o_busy), 0);
        check({tag, "_done"}, 32'(o_done), 0);
        check({tag, "_data"}, 32'(o_tx_data), 0);
        check({tag, "_regnum"}, 32'(o_mips_register_number), 0);
    endtask

    // Entered just after a falling edge; drives one dump and scores every byte.
    task automatic run_dump(input bit busy_start, input int rst_byte, input bit spur, input bit stab);
        logic [31:0] w;
        int nb, nd, wait_cnt;
        bit rst_arm, fin;
        nb = 0; nd = 0; wait_cnt = 0; rst_arm = 0; fin = 0;
        for (int r = 0; r < 32; r++) begin
            w = 32'h1234_5600 + 32'(r);
            for (int b = 3; b >= 0; b--) exp_q.push_back(w[b*8 +: 8]);
        end
        i_start = 1;
        for (int cyc = 1; cyc <= 3000 && !fin; cyc++) begin
            @(negedge i_clk);
            i_start   = 0;
            i_tx_done = 0;
            if (cyc == 1) check("load_busy", 32'(o_busy), 1);
            if (rst_arm) begin
                #2 i_reset = 1;
                #1 check_reset_outputs("async_rst");
                @(negedge i_clk);
                i_reset = 0;
                exp_q.delete();
                repeat (20) begin
                    @(negedge i_clk);
                    check("rst_quiet", 32'({o_tx_start, o_busy}), 0);
                end
                return;
            end
            if (o_tx_start) begin
                if (nb == 0) check("latency", 32'(cyc), 2);
                check("reg_num", 32'(o_mips_register_number), 32'(nb / 4));
                if (exp_q.size() == 0) check("extra_byte", 32'(nb), 127);
                else check("tx_byte", 32'(o_tx_data), 32'(exp_q.pop_front()));
                nb++;
                wait_cnt = 3;
                if (spur) i_tx_done = 1;
                if (busy_start && (nb == 6 || nb == 61)) i_start = 1;
                if (stab) override = (nb >= 13 && nb <= 15);
                if (nb - 1 == rst_byte) rst_arm = 1;
            end else if (wait_cnt > 0) begin
                wait_cnt--;
                if (wait_cnt == 0) i_tx_done = 1;
            end
            if (o_done) begin
                nd++;
                fin = 1;
            end
        end
        check("done_count", 32'(nd), 1);
        check("byte_count", 32'(nb), 128);
        check("queue_empty", 32'(exp_q.size()), 0);
        exp_q.delete();
        override = 0;
        repeat (10) begin
            @(negedge i_clk);
            check("post_done_idle", 32'({o_busy, o_done, o_tx_start}), 0);
        end
    endtask

    initial begin
        i_reset = 1; i_start = 0; i_tx_done = 0; override = 0;
        #3 check_reset_outputs("por");
        @(negedge i_clk);
        i_reset = 0;
        i_start = 0;
        i_tx_done = 1;
        @(negedge i_clk);
        i_tx_done = 0;
        check("idle_spurious_done", 32'(o_busy), 0);
        @(negedge i_clk);
        run_dump(0, -1, 0, 0);
        run_dump(1, -1, 0, 0);
        run_dump(0, -1, 1, 1);
        run_dump(0, 50, 0, 0);
        run_dump(0, -1, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
